fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences the fetch stage: arbitrates PC redirect sources, merges decode backpressure into fetch stall,
//  and kills wrong-path fetch output. Drives fetch stall_i / pc_sel_i / br_dest. Consumes ROB flush,
//  branch-unit mispredict, commit halt. Fetch timing it controls: pc reg -> imem addr -> inst/pc regs (1 cycle).
// PARAMETERS
//  XLEN      32  PC/target width
//  PERF_W    16  width of perf counters (FETCH_CTRL_PERF_EN only)
// PORTS
//  clk_i           in   1     clock, rising edge
//  reset_i         in   1     synchronous, active-high reset
//  rob_flush_i     in   1     commit-time flush request (highest priority)
//  rob_flush_pc_i  in   XLEN  flush target
//  br_mispred_i    in   1     branch-unit mispredict
//  br_target_i     in   XLEN  mispredict target
//  halt_i          in   1     commit retired halt (ecall/ebreak)
//  dec_stall_i     in   1     decode/issue full; hold fetch
//  stall_o         out  1     -> fetch stall_i
//  pc_sel_o        out  1     -> fetch pc_sel_i (1 = load br_dest_o)
//  br_dest_o       out  XLEN  -> fetch br_dest
//  kill_o          out  1     fetch inst/pc outputs this cycle are wrong-path; consumer drops them
//  fault_o         out  1     sticky: misaligned redirect target seen
//  state_o         out  2     FSM state (debug)
//  redir_cnt_o     out  PERF_W  accepted redirects (0 without macro)
//  stall_cnt_o     out  PERF_W  cycles stall_o=1 (0 without macro)
// BEHAVIOUR
//  FSM: BOOT(0) RUN(1) REDIR(2) HALT(3). Reset -> BOOT; all outputs 0, br_dest_o=0, counters 0.
//  - BOOT: one cycle, kill_o=1 (fetch output invalid after reset); -> RUN.
//  - Request select (comb): rob_flush_i > br_mispred_i; same-cycle loser dropped.
//  - Accept in RUN or REDIR: pc_sel_o=1, br_dest_o=selected target (comb), stall_o=0 that cycle
//    (redirect overrides dec_stall_i, else fetch ignores pc_sel), kill_o=1; -> REDIR.
//  - REDIR: kill_o=1 (inst from pre-redirect PC still in fetch output reg); new accept -> stays REDIR, else -> RUN.
//  - Kill window: accept at T -> kill_o at T and T+1; first target inst valid at T+2.
//  - RUN, no request: stall_o=dec_stall_i, pc_sel_o=0, kill_o=0.
//  - Misaligned target (tgt[1:0]!=0): not accepted, fault_o set (sticky until reset), -> HALT.
//  - halt_i in RUN/REDIR (lower priority than same-cycle flush): -> HALT.
//  - HALT: stall_o=1, kill_o=1; br_mispred_i ignored; aligned rob_flush_i accepted (pc_sel_o=1, stall_o=0) -> REDIR.
//  - reset_i wins over everything, any state, mid-window: -> BOOT next cycle.
//  - All outputs except state_o/fault_o/counters are combinational from state + inputs; no comb path input->state_o.
// CONFIGURATION
//  FETCH_CTRL_PERF_EN defined: redir_cnt_o +1 per accept; stall_cnt_o +1 per cycle stall_o=1;
//   both saturate at 2^PERF_W-1, cleared by reset.
//  Undefined: counters not instantiated, redir_cnt_o/stall_cnt_o tied 0; ports always present.
// STRUCTURE
//  fetch_pkg: state encoding localparams (BOOT/RUN/REDIR/HALT), cause codes (NONE/FLUSH/MISPRED).
//  Sub-module sat_counter #(W) (inc, clear, count) instantiated twice under FETCH_CTRL_PERF_EN.
//  Rest flat: next-state logic, select mux, fault flop.
// TESTING
//  1 reset 3 cycles, release -> BOOT 1 cycle kill_o=1, then RUN, stall_o=0, pc_sel_o=0, fault_o=0.
//  2 RUN, br_mispred_i=1 tgt=0x40 at T -> pc_sel_o=1 br_dest_o=0x40 at T; kill_o=1 T,T+1; fetch pc_o=0x40 valid T+2.
//  3 rob_flush_i(0x100) + br_mispred_i(0x40) same cycle, dec_stall_i=1 -> br_dest_o=0x100, stall_o=0; redir_cnt_o=1.
//  4 br_mispred_i tgt=0x42 -> pc_sel_o=0, fault_o=1, state_o=HALT, stall_o=1; later flush 0x0 -> REDIR, fault_o stays 1.
//  5 halt_i -> HALT; br_mispred_i 0x80 ignored; rob_flush_i 0x20 -> pc_sel_o=1, then RUN after 1 REDIR cycle.
//  6 back-to-back mispredicts T,T+1 (0x40,0x80) -> kill_o T..T+2, fetch pc_o=0x80 at T+3; reset_i at T+1 -> BOOT.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch control slice: FSM state encoding and redirect cause codes.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_REDIR = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_FLUSH   = 2'd1,
      CAUSE_MISPRED = 2'd2
   } redir_cause_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for fetch performance counters.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         clear_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         count_o <= '0;
      end else if (inc_i && (count_o != '1)) begin
         count_o <= count_o + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing: redirect arbitration, stall merge, wrong-path kill, fault/halt handling.
// Optional perf counters enabled by FETCH_CTRL_PERF_EN.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int PERF_W = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              rob_flush_i,
   input  logic [XLEN-1:0]   rob_flush_pc_i,
   input  logic              br_mispred_i,
   input  logic [XLEN-1:0]   br_target_i,
   input  logic              halt_i,
   input  logic              dec_stall_i,
   output logic              stall_o,
   output logic              pc_sel_o,
   output logic [XLEN-1:0]   br_dest_o,
   output logic              kill_o,
   output logic              fault_o,
   output logic [1:0]        state_o,
   output logic [PERF_W-1:0] redir_cnt_o,
   output logic [PERF_W-1:0] stall_cnt_o
);

   fetch_state_e    state_q, state_d;
   redir_cause_e    cause;
   logic [XLEN-1:0] tgt;
   logic            req_live;
   logic            misaligned;
   logic            accept;

   // Mispredicts are dead once halted; only commit flushes can restart fetch.
   always_comb begin
      cause = CAUSE_NONE;
      tgt   = '0;
      if (rob_flush_i) begin
         cause = CAUSE_FLUSH;
         tgt   = rob_flush_pc_i;
      end else if (br_mispred_i && (state_q != ST_HALT)) begin
         cause = CAUSE_MISPRED;
         tgt   = br_target_i;
      end
   end

   assign req_live   = (cause != CAUSE_NONE) && (state_q != ST_BOOT) && !reset_i;
   assign misaligned = req_live && (tgt[1:0] != 2'b00);
   assign accept     = req_live && !misaligned;

   always_comb begin
      state_d   = state_q;
      stall_o   = 1'b0;
      pc_sel_o  = 1'b0;
      br_dest_o = '0;
      kill_o    = 1'b0;
      case (state_q)
         ST_BOOT: begin
            kill_o  = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN, ST_REDIR: begin
            kill_o  = (state_q == ST_REDIR);
            stall_o = dec_stall_i;
            if (accept) begin
               pc_sel_o  = 1'b1;
               br_dest_o = tgt;
               stall_o   = 1'b0;
               kill_o    = 1'b1;
               state_d   = ST_REDIR;
            end else if (misaligned || halt_i) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            stall_o = 1'b1;
            kill_o  = 1'b1;
            if (accept) begin
               pc_sel_o  = 1'b1;
               br_dest_o = tgt;
               stall_o   = 1'b0;
               state_d   = ST_REDIR;
            end
         end
         default: state_d = ST_BOOT;
      endcase
      // Reset quiets every combinational output, whatever the current state.
      if (reset_i) begin
         stall_o   = 1'b0;
         pc_sel_o  = 1'b0;
         br_dest_o = '0;
         kill_o    = 1'b0;
         state_d   = ST_BOOT;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_BOOT;
         fault_o <= 1'b0;
      end else begin
         state_q <= state_d;
         if (misaligned) begin
            fault_o <= 1'b1;
         end
      end
   end

   assign state_o = state_q;

`ifdef FETCH_CTRL_PERF_EN
   sat_counter #(.W(PERF_W)) u_redir_cnt (
      .clk_i   (clk_i),
      .clear_i (reset_i),
      .inc_i   (accept),
      .count_o (redir_cnt_o)
   );

   sat_counter #(.W(PERF_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .clear_i (reset_i),
      .inc_i   (stall_o),
      .count_o (stall_cnt_o)
   );
`else
   assign redir_cnt_o = '0;
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl: one vector per clock cycle plus a counter sequence.
module tb_fetch_ctrl;

   localparam int XLEN   = 32;
   localparam int PERF_W = 16;

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic              rob_flush_i;
   logic [XLEN-1:0]   rob_flush_pc_i;
   logic              br_mispred_i;
   logic [XLEN-1:0]   br_target_i;
   logic              halt_i;
   logic              dec_stall_i;
   logic              stall_o;
   logic              pc_sel_o;
   logic [XLEN-1:0]   br_dest_o;
   logic              kill_o;
   logic              fault_o;
   logic [1:0]        state_o;
   logic [PERF_W-1:0] redir_cnt_o;
   logic [PERF_W-1:0] stall_cnt_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   fetch_ctrl #(.XLEN(XLEN), .PERF_W(PERF_W)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .rob_flush_i    (rob_flush_i),
      .rob_flush_pc_i (rob_flush_pc_i),
      .br_mispred_i   (br_mispred_i),
      .br_target_i    (br_target_i),
      .halt_i         (halt_i),
      .dec_stall_i    (dec_stall_i),
      .stall_o        (stall_o),
      .pc_sel_o       (pc_sel_o),
      .br_dest_o      (br_dest_o),
      .kill_o         (kill_o),
      .fault_o        (fault_o),
      .state_o        (state_o),
      .redir_cnt_o    (redir_cnt_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   typedef struct {
      logic        rst;
      logic        flush;
      logic [31:0] flush_pc;
      logic        mis;
      logic [31:0] mis_tgt;
      logic        halt;
      logic        dstall;
      logic        e_stall;
      logic        e_psel;
      logic [31:0] e_dest;
      logic        e_kill;
      logic        e_fault;
      logic [1:0]  e_state;
   } vec_t;

   localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_REDIR = 2'd2, S_HALT = 2'd3;

   vec_t vecs[$];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic fl, input logic [31:0] fpc,
                      input logic mis, input logic [31:0] mt, input logic hlt, input logic ds,
                      input logic es, input logic ep, input logic [31:0] ed,
                      input logic ek, input logic ef, input logic [1:0] est);
      vec_t v;
      v.rst = rst; v.flush = fl; v.flush_pc = fpc; v.mis = mis; v.mis_tgt = mt;
      v.halt = hlt; v.dstall = ds; v.e_stall = es; v.e_psel = ep; v.e_dest = ed;
      v.e_kill = ek; v.e_fault = ef; v.e_state = est;
      vecs.push_back(v);
   endtask

   task automatic drive_idle();
      reset_i = 1'b0; rob_flush_i = 1'b0; rob_flush_pc_i = '0; br_mispred_i = 1'b0;
      br_target_i = '0; halt_i = 1'b0; dec_stall_i = 1'b0;
   endtask

   initial begin
      //   rst fl fpc        mis tgt      hlt ds | stall psel dest      kill fault state
      add(1, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   0, 0, S_BOOT);   // in reset
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   1, 0, S_BOOT);   // boot kill cycle
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   0, 0, S_RUN);
      add(0, 0, 32'h0,   0, 32'h0,  0, 1,  1, 0, 32'h0,   0, 0, S_RUN);    // decode backpressure
      add(0, 0, 32'h0,   1, 32'h40, 0, 0,  0, 1, 32'h40,  1, 0, S_RUN);    // T: mispredict
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   1, 0, S_REDIR);  // T+1 still killed
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   0, 0, S_RUN);    // T+2 valid
      add(0, 1, 32'h100, 1, 32'h40, 0, 1,  0, 1, 32'h100, 1, 0, S_RUN);    // flush beats mispred, stall overridden
      add(0, 0, 32'h0,   0, 32'h0,  0, 1,  1, 0, 32'h0,   1, 0, S_REDIR);
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   0, 0, S_RUN);
      add(0, 0, 32'h0,   1, 32'h42, 0, 0,  0, 0, 32'h0,   0, 0, S_RUN);    // misaligned target
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  1, 0, 32'h0,   1, 1, S_HALT);
      add(0, 0, 32'h0,   1, 32'h80, 0, 0,  1, 0, 32'h0,   1, 1, S_HALT);   // mispred ignored in HALT
      add(0, 1, 32'h0,   0, 32'h0,  0, 0,  0, 1, 32'h0,   1, 1, S_HALT);   // flush to 0x0 restarts
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   1, 1, S_REDIR);
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   0, 1, S_RUN);    // fault sticky
      add(1, 0, 32'h0,   0, 32'h0,  0, 1,  0, 0, 32'h0,   0, 1, S_RUN);    // reset asserted
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   1, 0, S_BOOT);
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   0, 0, S_RUN);
      add(0, 0, 32'h0,   0, 32'h0,  1, 0,  0, 0, 32'h0,   0, 0, S_RUN);    // commit halt
      add(0, 0, 32'h0,   1, 32'h80, 0, 0,  1, 0, 32'h0,   1, 0, S_HALT);
      add(0, 1, 32'h20,  0, 32'h0,  0, 0,  0, 1, 32'h20,  1, 0, S_HALT);
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   1, 0, S_REDIR);
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   0, 0, S_RUN);
      add(0, 0, 32'h0,   1, 32'h40, 0, 0,  0, 1, 32'h40,  1, 0, S_RUN);    // back-to-back T
      add(0, 0, 32'h0,   1, 32'h80, 0, 0,  0, 1, 32'h80,  1, 0, S_REDIR);  // T+1
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   1, 0, S_REDIR);  // T+2
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   0, 0, S_RUN);    // T+3 valid
      add(0, 0, 32'h0,   1, 32'h40, 0, 0,  0, 1, 32'h40,  1, 0, S_RUN);
      add(1, 0, 32'h0,   1, 32'h80, 0, 0,  0, 0, 32'h0,   0, 0, S_REDIR);  // reset mid-window
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   1, 0, S_BOOT);
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   0, 0, S_RUN);
      add(0, 1, 32'h200, 0, 32'h0,  1, 0,  0, 1, 32'h200, 1, 0, S_RUN);    // flush beats halt
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   1, 0, S_REDIR);
      add(0, 0, 32'h0,   0, 32'h0,  0, 0,  0, 0, 32'h0,   0, 0, S_RUN);

      drive_idle();
      reset_i = 1'b1;
      repeat (3) @(posedge clk_i);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk_i);
         reset_i        = vecs[i].rst;
         rob_flush_i    = vecs[i].flush;
         rob_flush_pc_i = vecs[i].flush_pc;
         br_mispred_i   = vecs[i].mis;
         br_target_i    = vecs[i].mis_tgt;
         halt_i         = vecs[i].halt;
         dec_stall_i    = vecs[i].dstall;
         #1;
         chk("state", i, 32'(state_o), 32'(vecs[i].e_state));
         chk("stall", i, 32'(stall_o), 32'(vecs[i].e_stall));
         chk("pc_sel", i, 32'(pc_sel_o), 32'(vecs[i].e_psel));
         chk("br_dest", i, br_dest_o, vecs[i].e_dest);
         chk("kill", i, 32'(kill_o), 32'(vecs[i].e_kill));
         chk("fault", i, 32'(fault_o), 32'(vecs[i].e_fault));
      end

      // Counter sequence: since the last reset, one accept (flush 0x200), then 3 stall cycles.
      @(negedge clk_i);
      drive_idle();
      dec_stall_i = 1'b1;
      repeat (3) @(negedge clk_i);
      drive_idle();
      #1;
`ifdef FETCH_CTRL_PERF_EN
      chk("redir_cnt", 100, 32'(redir_cnt_o), 32'd1);
      chk("stall_cnt", 100, 32'(stall_cnt_o), 32'd3);
`else
      chk("redir_cnt", 100, 32'(redir_cnt_o), 32'd0);
      chk("stall_cnt", 100, 32'(stall_cnt_o), 32'd0);
`endif
      chk("state_end", 100, 32'(state_o), 32'(S_RUN));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
